// File: rtl/if_stage_if.sv
// Signal bundle between the fetch stage and its neighbours: the hazard unit, EX redirect, imem and ID.
// The master modport is the fetch stage; the slave modport is everything around it.
interface if_stage_if;
    logic        stall;
    logic        flush_if_id;
    logic        tk_brnch_ex;
    logic [31:0] brnch_target_ex;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic [31:0] pc_id;
    logic [31:0] pc4_id;
    logic [31:0] instr_id;
    logic        valid_id;
    logic        misalign_id;

    modport master (
        input  stall,
        input  flush_if_id,
        input  tk_brnch_ex,
        input  brnch_target_ex,
        input  imem_rdata,
        output imem_addr,
        output imem_req,
        output pc_id,
        output pc4_id,
        output instr_id,
        output valid_id,
        output misalign_id
    );

    modport slave (
        output stall,
        output flush_if_id,
        output tk_brnch_ex,
        output brnch_target_ex,
        output imem_rdata,
        input  imem_addr,
        input  imem_req,
        input  pc_id,
        input  pc4_id,
        input  instr_id,
        input  valid_id,
        input  misalign_id
    );
endinterface

// File: rtl/if_stage.sv
// RV32I instruction fetch stage with IF/ID register; owns the fetch PC and drives a synchronous imem.
// Keeps a captured copy of the fetched word while stalled so ID sees a stable instruction.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic       clk,
    input  logic       rst,
    if_stage_if.master bus
);

    logic [31:0] pc_f_q,       pc_f_d;
    logic [31:0] pc_id_q,      pc_id_d;
    logic        valid_id_q,   valid_id_d;
    logic        misalign_q,   misalign_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_instr_q, hold_instr_d;

    // Priority: redirect beats stall beats normal advance; reset is applied in the register block.
    always_comb begin
        pc_f_d       = pc_f_q;
        pc_id_d      = pc_id_q;
        valid_id_d   = valid_id_q;
        misalign_d   = misalign_q;
        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        if (bus.tk_brnch_ex) begin
            pc_f_d       = {bus.brnch_target_ex[31:1], 1'b0};
            valid_id_d   = 1'b0;
            hold_valid_d = 1'b0;
        end else if (bus.stall) begin
            // imem keeps re-reading pc_f, so the word for pc_id must be latched on the first stall cycle
            if (!hold_valid_q) begin
                hold_instr_d = bus.imem_rdata;
                hold_valid_d = 1'b1;
            end
        end else begin
            pc_id_d      = pc_f_q;
            valid_id_d   = !bus.flush_if_id;
            misalign_d   = pc_f_q[1];
            pc_f_d       = pc_f_q + 32'd4;
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f_q       <= RESET_PC;
            pc_id_q      <= 32'd0;
            valid_id_q   <= 1'b0;
            misalign_q   <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_instr_q <= 32'd0;
        end else begin
            pc_f_q       <= pc_f_d;
            pc_id_q      <= pc_id_d;
            valid_id_q   <= valid_id_d;
            misalign_q   <= misalign_d;
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    always_comb begin
        bus.instr_id = bus.imem_rdata;
        if (!valid_id_q) begin
            bus.instr_id = NOP_INSTR;
        end else if (hold_valid_q) begin
            bus.instr_id = hold_instr_q;
        end
    end

    assign bus.imem_addr   = pc_f_q;
    assign bus.imem_req    = !rst;
    assign bus.pc_id       = pc_id_q;
    assign bus.pc4_id      = pc_id_q + 32'd4;
    assign bus.valid_id    = valid_id_q;
    assign bus.misalign_id = misalign_q;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction fetch stage and IF/ID pipeline register of the 5-stage RV32I core, directly upstream of the decode stage.
- Owns the fetch PC and drives the synchronous instruction memory.
- Consumes stall and flush_if_id from the hazard unit, plus the taken-branch redirect from EX.
- Presents pc/instruction/valid to ID.
- Because imem read data arrives one cycle after the address, it holds a captured instruction across stalls so that ID sees a stable instruction.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset (must be 4-byte aligned)
NOP_INSTR, 32'h0000_0013, instruction presented to ID when valid_id=0 (addi x0,x0,0)

Ports:
clk  in  1  single clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
stall  in  1  from hazard unit; freeze PC and IF/ID register
flush_if_id  in  1  from hazard unit; invalidate IF/ID contents
tk_brnch_ex  in  1  taken branch/jump resolved in EX
brnch_target_ex  in  32  redirect target from EX
imem_addr  out  32  instruction memory address (= pc_f)
imem_req  out  1  read request; 0 only while rst=1
imem_rdata  in  32  instruction for the address presented the previous cycle
pc_id  out  32  PC of instruction in ID
pc4_id  out  32  pc_id + 4
instr_id  out  32  instruction in ID
valid_id  out  1  ID holds a real instruction
misalign_id  out  1  instruction in ID was fetched from a target with bit[1]=1

Behaviour:
- Reset (rst=1 at edge):
  - pc_f=RESET_PC; pc_id=0; valid_id=0; hold_valid=0; hold_instr=0; misalign_id=0.
  - imem_req=0 combinationally while rst=1.
  - Reset mid-stall or mid-redirect discards all state.
- imem_addr = pc_f, combinational. imem_rdata at cycle N+1 belongs to imem_addr at cycle N, which is the instruction for pc_id at N+1.
- instr_id:
  - NOP_INSTR if valid_id=0.
  - Otherwise hold_instr if hold_valid=1.
  - Otherwise imem_rdata.
  - Combinational, no extra latency.
- Priority per edge: rst > redirect (tk_brnch_ex) > stall > normal advance.
- Redirect (tk_brnch_ex=1):
  - pc_f<=brnch_target_ex with bit[0] forced 0; valid_id<=0; hold_valid<=0.
  - Applies even if stall=1, because the hazard unit may assert both and the branch wins.
- Flush without branch (flush_if_id=1, tk_brnch_ex=0, stall=0): valid_id<=0 and pc_f advances normally.
- Stall (stall=1, no redirect):
  - pc_f, pc_id, valid_id and misalign_id hold.
  - First stall cycle (hold_valid=0): hold_instr<=imem_rdata and hold_valid<=1. This is needed because imem re-reads pc_f, so rdata would otherwise change underneath ID.
  - Subsequent stall cycles: hold contents unchanged.
- Normal advance (no stall, no redirect):
  - pc_id<=pc_f; valid_id<=!flush_if_id; pc_f<=pc_f+4 (32-bit wrap: 32'hFFFF_FFFC -> 0); hold_valid<=0.
  - misalign_id<=pc_f[1].
- Flush_if_id together with stall and no branch: stall wins (IF/ID holds). The hazard unit never raises this combination without tk_brnch_ex.
- First cycle after rst falls: valid_id=0. First valid instruction (pc_id=RESET_PC) appears one cycle later.
- Misaligned fetch: no exception raised here. misalign_id is only a flag to ID; the address is issued unchanged.

Test Plan:
- Reset release, RESET_PC=0, imem returns word addr*4+1 → imem_addr 0,4,8,…; valid_id=0 in cycle 1; then pc_id=0/instr_id=1, pc_id=4/instr_id=5, one per cycle; pc4_id=pc_id+4.
- Stall 3 cycles while pc_id=8 → pc_id=8, instr_id=9, imem_addr=12 held for all 3 cycles. The memory changing rdata to 13 does not affect instr_id. On release, pc_id=12/instr_id=13 next cycle.
- tk_brnch_ex=1, target=0x100 → next cycle valid_id=0, instr_id=NOP 0x13, imem_addr=0x100. Following cycle pc_id=0x100 valid.
- tk_brnch_ex=1 and stall=1 same cycle, target 0x40 → redirect taken: imem_addr=0x40, valid_id=0, hold cleared.
- Target 0x102 → imem_addr=0x102; next cycle misalign_id=1 with pc_id=0x102. Target 0x103 → bit0 cleared, imem_addr=0x102.
- rst asserted during a 2-cycle stall → next cycle valid_id=0, imem_req=0, pc_f=RESET_PC, hold_valid=0; fetch restarts cleanly at RESET_PC.
